// File: rtl/rv_dmem_resp.sv
// RV64 data-memory responder: valid/ready request and response channels,
// byte/half/word/double loads and stores with wait states and error reporting.
module rv_dmem_resp #(
    parameter int    DEPTH     = 128,
    parameter int    WAIT_CYC  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem [DEPTH];

    // In IDLE the live request drives the datapath so WAIT_CYC=0 can access on the accept edge.
    logic [31:0]      acc_addr;
    logic             acc_we;
    logic [1:0]       acc_size;
    logic             acc_uns;
    logic [63:0]      acc_wdata;
    logic [2:0]       off;
    logic [5:0]       bit_off;
    logic             misal, oor, acc_err;
    logic [IDX_W-1:0] idx;
    logic [63:0]      rd_word, shifted, ld_data, size_mask, bmask, merged;
    logic             do_acc, latch, wr_en;

    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr  = req_addr_i;
            acc_we    = req_we_i;
            acc_size  = req_size_i;
            acc_uns   = req_unsigned_i;
            acc_wdata = req_wdata_i;
        end else begin
            acc_addr  = addr_q;
            acc_we    = we_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        off     = acc_addr[2:0];
        bit_off = {off, 3'b000};
        case (acc_size)
            2'd0:    misal = 1'b0;
            2'd1:    misal = acc_addr[0];
            2'd2:    misal = |acc_addr[1:0];
            default: misal = |acc_addr[2:0];
        endcase
        oor     = {3'b000, acc_addr[31:3]} >= DEPTH_W;
        acc_err = misal | oor;
        idx     = acc_addr[3 +: IDX_W];
        rd_word = mem[idx];
        shifted = rd_word >> bit_off;
        case (acc_size)
            2'd0: begin
                size_mask = 64'h0000_0000_0000_00FF;
                ld_data   = acc_uns ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
            end
            2'd1: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                ld_data   = acc_uns ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            end
            2'd2: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                ld_data   = acc_uns ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            end
            default: begin
                size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                ld_data   = shifted;
            end
        endcase
        bmask  = size_mask << bit_off;
        merged = (rd_word & ~bmask) | ((acc_wdata << bit_off) & bmask);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        do_acc  = 1'b0;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    latch = 1'b1;
                    if (WAIT_CYC == 0) begin
                        do_acc  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_acc  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (do_acc) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 64'd0 : ld_data;
        end
        wr_en = do_acc & acc_we & ~acc_err;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (latch) begin
                addr_q  <= req_addr_i;
                we_q    <= req_we_i;
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

    // Storage has no reset; a reset during WAIT simply never reaches the write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= merged;
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed bench for rv_dmem_resp: one instance with WAIT_CYC=1, one with WAIT_CYC=4.
module tb_rv_dmem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn0, rstn1, sel, req_valid, we, uns, rsp_ready;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;

    logic        rdy0, vld0, err0, rdy1, vld1, err1;
    logic [63:0] rd0, rd1;
    logic        rdy, vld, err;
    logic [63:0] rd;

    int nchk = 0;
    int nerr = 0;

    rv_dmem_resp #(.DEPTH(128), .WAIT_CYC(1), .INIT_FILE("")) u0 (
        .clk(clk), .rstn(rstn0),
        .req_valid_i(req_valid & ~sel), .req_ready_o(rdy0),
        .req_addr_i(addr), .req_we_i(we), .req_size_i(size),
        .req_unsigned_i(uns), .req_wdata_i(wdata),
        .rsp_valid_o(vld0), .rsp_ready_i(rsp_ready & ~sel),
        .rsp_rdata_o(rd0), .rsp_err_o(err0)
    );

    rv_dmem_resp #(.DEPTH(128), .WAIT_CYC(4), .INIT_FILE("")) u1 (
        .clk(clk), .rstn(rstn1),
        .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
        .req_addr_i(addr), .req_we_i(we), .req_size_i(size),
        .req_unsigned_i(uns), .req_wdata_i(wdata),
        .rsp_valid_o(vld1), .rsp_ready_i(rsp_ready & sel),
        .rsp_rdata_o(rd1), .rsp_err_o(err1)
    );

    assign rdy = sel ? rdy1 : rdy0;
    assign vld = sel ? vld1 : vld0;
    assign err = sel ? err1 : err0;
    assign rd  = sel ? rd1  : rd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; checks accept, latency, rdata and err, then handshakes.
    task automatic xact(input bit s, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input bit exp_err, input string tag);
        int n;
        int lat;
        @(negedge clk);
        sel = s; we = w; size = sz; uns = u; addr = a; wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!rdy && n < 50) begin @(negedge clk); n++; end
        chk({tag, ".acc"}, 64'(rdy), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!vld && lat < 40) begin lat++; @(negedge clk); end
        chk({tag, ".lat"}, 64'(lat), s ? 64'd4 : 64'd1);
        chk({tag, ".rd"}, rd, exp_rd);
        chk({tag, ".err"}, 64'(err), 64'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn0 = 1'b0; rstn1 = 1'b0; sel = 1'b0; req_valid = 1'b0; we = 1'b0;
        uns = 1'b0; rsp_ready = 1'b0; size = 2'd0; addr = 32'd0; wdata = 64'd0;
        repeat (2) @(negedge clk);
        chk("rst.rdy0", 64'(rdy0), 64'd1);
        chk("rst.vld0", 64'(vld0), 64'd0);
        chk("rst.rd0", rd0, 64'd0);
        chk("rst.err0", 64'(err0), 64'd0);
        chk("rst.rdy1", 64'(rdy1), 64'd1);
        chk("rst.vld1", 64'(vld1), 64'd0);
        rstn0 = 1'b1; rstn1 = 1'b1;
        @(negedge clk);
        chk("post_rst.rdy0", 64'(rdy0), 64'd1);

        // double store/load
        xact(0, 1, 2'd3, 0, 32'h10, 64'h0123_4567_89AB_CDEF, 64'd0, 0, "sd10");
        xact(0, 0, 2'd3, 0, 32'h10, 64'd0, 64'h0123_4567_89AB_CDEF, 0, "ld10");
        // byte lanes; upper wdata bits must be ignored
        xact(0, 1, 2'd0, 0, 32'h13, 64'hAAAA_AAAA_AAAA_AA80, 64'd0, 0, "sb13");
        xact(0, 0, 2'd0, 0, 32'h13, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 0, "lb13");
        xact(0, 0, 2'd0, 1, 32'h13, 64'd0, 64'h0000_0000_0000_0080, 0, "lbu13");
        xact(0, 0, 2'd3, 0, 32'h10, 64'd0, 64'h0123_4567_80AB_CDEF, 0, "ld10b");
        // half/word extension
        xact(0, 1, 2'd2, 0, 32'h20, 64'h5A5A_5A5A_8000_1234, 64'd0, 0, "sw20");
        xact(0, 0, 2'd2, 0, 32'h20, 64'd0, 64'hFFFF_FFFF_8000_1234, 0, "lw20");
        xact(0, 0, 2'd2, 1, 32'h20, 64'd0, 64'h0000_0000_8000_1234, 0, "lwu20");
        xact(0, 0, 2'd1, 0, 32'h22, 64'd0, 64'hFFFF_FFFF_FFFF_8000, 0, "lh22");
        xact(0, 0, 2'd1, 1, 32'h20, 64'd0, 64'h0000_0000_0000_1234, 0, "lhu20");
        // errors
        xact(0, 1, 2'd3, 0, 32'h0, 64'h5555_0000_AAAA_1111, 64'd0, 0, "sd00");
        xact(0, 0, 2'd1, 0, 32'h21, 64'd0, 64'd0, 1, "lh21");
        xact(0, 1, 2'd3, 0, 32'h400, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1, "sd400");
        xact(0, 1, 2'd3, 0, 32'h404, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1, "sd404");
        xact(0, 0, 2'd3, 0, 32'h400, 64'd0, 64'd0, 1, "ld400");
        xact(0, 0, 2'd3, 0, 32'h0, 64'd0, 64'h5555_0000_AAAA_1111, 0, "ld00");
        xact(0, 0, 2'd3, 0, 32'h10, 64'd0, 64'h0123_4567_80AB_CDEF, 0, "ld10c");
        xact(0, 0, 2'd2, 1, 32'h20, 64'd0, 64'h0000_0000_8000_1234, 0, "lwu20b");

        // backpressure: hold rsp_ready low for 5 cycles
        @(negedge clk);
        sel = 1'b0; we = 1'b0; size = 2'd3; uns = 1'b0; addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!vld && n < 40) begin n++; @(negedge clk); end
        chk("bp.vld0", 64'(vld), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp.vld", 64'(vld), 64'd1);
            chk("bp.rd", rd, 64'h0123_4567_80AB_CDEF);
            chk("bp.rdy", 64'(rdy), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp.rel_rdy", 64'(rdy), 64'd1);
        chk("bp.rel_vld", 64'(vld), 64'd0);
        xact(0, 0, 2'd0, 1, 32'h10, 64'd0, 64'h0000_0000_0000_00EF, 0, "bp.next");

        // reset during WAIT on the WAIT_CYC=4 instance
        xact(1, 1, 2'd3, 0, 32'h30, 64'h0000_0000_0000_1111, 64'd0, 0, "w4.sd30");
        xact(1, 0, 2'd3, 0, 32'h30, 64'd0, 64'h0000_0000_0000_1111, 0, "w4.ld30");
        @(negedge clk);
        sel = 1'b1; we = 1'b1; size = 2'd3; uns = 1'b0; addr = 32'h30;
        wdata = 64'h0000_0000_0000_DEAD; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("w4.wait_rdy", 64'(rdy), 64'd0);
        @(negedge clk);
        rstn1 = 1'b0;
        #1;
        chk("w4.rst_rdy", 64'(rdy1), 64'd1);
        chk("w4.rst_vld", 64'(vld1), 64'd0);
        chk("w4.rst_rd", rd1, 64'd0);
        chk("w4.rst_err", 64'(err1), 64'd0);
        @(negedge clk);
        rstn1 = 1'b1;
        xact(1, 0, 2'd3, 0, 32'h30, 64'd0, 64'h0000_0000_0000_1111, 0, "w4.ld30b");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
